uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of requesters, legal range 2..16.
REQ-002 SHALL have parameter DATA_WIDTH, default 8: bits per character.
REQ-003 SHALL have parameter TIMEOUT, default 16: max cycles waiting for tx_busy to rise; legal minimum 4.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port reset_n  input  1  synchronous, active-low reset.
REQ-006 SHALL have port req  input  NUM_REQ  per-requester request level.
REQ-007 SHALL have port req_data  input  NUM_REQ*DATA_WIDTH  character for requester i, in bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 SHALL have port grant  output  NUM_REQ  one-hot, one-cycle pulse; data of that requester has been captured.
REQ-009 SHALL have port tx_transmit  output  1  start request to the shared UART transmitter.
REQ-010 SHALL have port tx_data  output  DATA_WIDTH  character presented to the transmitter.
REQ-011 SHALL have port tx_busy  input  1  transmitter busy flag.
REQ-012 SHALL have port done  output  1  one-cycle pulse; frame for active_id is complete.
REQ-013 SHALL have port err  output  1  one-cycle pulse; tx_busy did not rise within TIMEOUT cycles.
REQ-014 SHALL have port active_id  output  $clog2(NUM_REQ)  index of the current or last granted requester.

Function
REQ-015 SHALL implement an FSM with states IDLE, ISSUE and WAIT_DONE, all outputs registered.
REQ-016 IDLE: when any req bit is 1 and tx_busy is 0, SHALL, on the same edge, select a winner, load tx_data from req_data[winner], set grant[winner]=1, active_id=winner and tx_transmit=1, and go to ISSUE.
REQ-017 IDLE with tx_busy=1 SHALL NOT issue, regardless of req.
REQ-018 Winner selection SHALL be round-robin: search starts at (last_owner+1) mod NUM_REQ and wraps; the first set req bit wins.
REQ-019 grant SHALL be high for exactly one cycle per issue; a requester may change req_data or drop req from the cycle after its grant.
REQ-020 tx_data SHALL remain stable from issue until the FSM returns to IDLE.
REQ-021 ISSUE: tx_transmit SHALL stay 1 and a wait counter SHALL increment each cycle; on tx_busy=1, tx_transmit<=0, counter<=0, go to WAIT_DONE.
REQ-022 ISSUE: if the counter reaches TIMEOUT-1 with tx_busy still 0, SHALL set tx_transmit<=0, pulse err, keep last_owner unchanged, and go to IDLE. The granted character is dropped.
REQ-023 WAIT_DONE: on tx_busy=0, SHALL pulse done, set last_owner=active_id, and go to IDLE.
REQ-024 A requester holding req continuously SHALL be re-granted no earlier than after every other active requester has been served once.
REQ-025 req changes during ISSUE or WAIT_DONE SHALL be ignored until IDLE.
REQ-026 Minimum spacing SHALL be one IDLE cycle between done and the next tx_transmit assertion.
REQ-027 A single-bit req SHALL be granted regardless of the pointer position, including wrap from NUM_REQ-1 to 0.

Reset
REQ-028 When reset_n=0 at a clock edge, SHALL set state=IDLE, tx_transmit=0, tx_data=0, grant=0, done=0, err=0, active_id=0, last_owner=NUM_REQ-1, and clear the wait counter.
REQ-029 Reset asserted in ISSUE or WAIT_DONE SHALL abort the transaction with no done or err pulse.
REQ-030 After reset, requester 0 SHALL have the highest priority.

Verification (NUM_REQ=4, DATA_WIDTH=8, TIMEOUT=16, real transmitter model)
REQ-031 Single request: req=0100, req_data[2]=0xA5 -> grant=0100 for 1 cycle, tx_data=0xA5, tx_transmit high until tx_busy rises, then done after tx_busy falls, active_id=2.
REQ-032 All requesting: req=1111 held, data 0x10/0x11/0x12/0x13 -> frames sent in order 0,1,2,3,0; each grant preceded by done of the prior frame.
REQ-033 Timeout: tx_busy tied 0, req=0001 -> tx_transmit high for 16 cycles, err pulses once, next grant goes to requester 0 again.
REQ-034 Busy at idle: tx_busy forced 1 in IDLE, req=1000 -> no grant until tx_busy=0, then grant=1000 on the following edge.
REQ-035 Reset mid-frame: reset_n=0 during WAIT_DONE -> next cycle all outputs at reset values, no done; after release, req=0011 grants requester 0 first.
REQ-036 Data hold: requester changes req_data the cycle after grant -> tx_data unchanged through the frame; serial line carries the original byte with even parity.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter among NUM_REQ requesters.
// It issues one character at a time and reports completion, or a timeout when the transmitter never goes busy.
module uart_tx_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 16
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [NUM_REQ-1:0]              req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]              grant,
  output logic                            tx_transmit,
  output logic [DATA_WIDTH-1:0]           tx_data,
  input  logic                            tx_busy,
  output logic                            done,
  output logic                            err,
  output logic [$clog2(NUM_REQ)-1:0]      active_id
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [ID_W-1:0]  LAST_RST = ID_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [NUM_REQ-1:0]      grant_q, grant_d;
  logic                    tx_q, tx_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;
  logic [ID_W-1:0]         id_q, id_d;
  logic [ID_W-1:0]         last_q, last_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;

  logic [DATA_WIDTH-1:0]   lane [NUM_REQ];
  logic                    win_found;
  logic [ID_W-1:0]         win_id;
  logic [31:0]             cand;

  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      lane[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Search begins one past the last requester that completed a frame and wraps.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    cand      = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = 32'(last_q) + 32'd1 + k;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end
      if (!win_found && req[cand[ID_W-1:0]]) begin
        win_found = 1'b1;
        win_id    = cand[ID_W-1:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = '0;
    tx_d    = tx_q;
    data_d  = data_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    id_d    = id_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (win_found && !tx_busy) begin
          grant_d[win_id] = 1'b1;
          tx_d            = 1'b1;
          data_d          = lane[win_id];
          id_d            = win_id;
          cnt_d           = '0;
          state_d         = ISSUE;
        end
      end
      ISSUE: begin
        if (tx_busy) begin
          tx_d    = 1'b0;
          cnt_d   = '0;
          state_d = WAIT_DONE;
        end else if (cnt_q == CNT_LAST) begin
          // Character is dropped; the pointer stays so the same requester is tried again.
          tx_d    = 1'b0;
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          done_d  = 1'b1;
          last_d  = id_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      tx_q    <= 1'b0;
      data_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      id_q    <= '0;
      last_q  <= LAST_RST;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      tx_q    <= tx_d;
      data_q  <= data_d;
      done_q  <= done_d;
      err_q   <= err_d;
      id_q    <= id_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  assign grant       = grant_q;
  assign tx_transmit = tx_q;
  assign tx_data     = data_q;
  assign done        = done_q;
  assign err         = err_q;
  assign active_id   = id_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: cycle vectors with a forced busy flag, then sequences
// against a UART transmitter model (start, 8 data, even parity, stop; one cycle per bit).
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  grant;
  logic        tx_transmit;
  logic [7:0]  tx_data;
  logic        tx_busy;
  logic        done;
  logic        err;
  logic [1:0]  active_id;

  logic        use_model;
  logic        busy_force;
  logic        busy_mdl = 1'b0;
  logic [10:0] sh, rxsh;
  int unsigned bitcnt;
  logic [10:0] rx_q [$];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign tx_busy = use_model ? busy_mdl : busy_force;

  uart_tx_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .TIMEOUT(16)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .req_data(req_data),
    .grant(grant), .tx_transmit(tx_transmit), .tx_data(tx_data),
    .tx_busy(tx_busy), .done(done), .err(err), .active_id(active_id)
  );

  // Transmitter model: accepts a start request while idle, shifts out a frame, records it.
  always @(posedge clk) begin
    if (!reset_n) begin
      busy_mdl <= 1'b0;
      bitcnt   <= 0;
    end else if (!busy_mdl) begin
      if (use_model && tx_transmit) begin
        sh       <= {1'b1, ^tx_data, tx_data, 1'b0};
        busy_mdl <= 1'b1;
        bitcnt   <= 0;
      end
    end else begin
      rxsh   <= {sh[0], rxsh[10:1]};
      sh     <= sh >> 1;
      bitcnt <= bitcnt + 1;
      if (bitcnt == 10) begin
        busy_mdl <= 1'b0;
        rx_q.push_back({sh[0], rxsh[10:1]});
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    req     = '0;
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  typedef struct {
    logic        rst_n;
    logic [3:0]  req;
    logic        busy;
    logic [3:0]  grant;
    logic        tx;
    logic        done;
    logic        err;
    logic [1:0]  id;
    logic [7:0]  txd;
  } vec_t;

  vec_t vt [$];

  initial begin : main
    int tx_cnt, err_cnt, gseen, ng, nd, hold_bad;
    bit done_seen, got_done;
    int exp_order [5];
    logic [7:0] b;

    exp_order = '{0, 1, 2, 3, 0};
    reset_n = 1'b0; req = '0; req_data = 32'h13A5_1110;
    use_model = 1'b0; busy_force = 1'b0;

    //            rst  req      busy   grant    tx    done  err   id    tx_data
    vt.push_back('{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00});
    vt.push_back('{1'b1, 4'b0100, 1'b0, 4'b0100, 1'b1, 1'b0, 1'b0, 2'd2, 8'hA5});
    vt.push_back('{1'b1, 4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd2, 8'hA5});
    vt.push_back('{1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd2, 8'hA5});
    vt.push_back('{1'b1, 4'b1111, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd2, 8'hA5});
    vt.push_back('{1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 2'd2, 8'hA5});
    vt.push_back('{1'b1, 4'b1111, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd2, 8'hA5});
    vt.push_back('{1'b1, 4'b1011, 1'b0, 4'b1000, 1'b1, 1'b0, 1'b0, 2'd3, 8'h13});
    vt.push_back('{1'b1, 4'b1011, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd3, 8'h13});
    vt.push_back('{1'b1, 4'b1011, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 2'd3, 8'h13});
    vt.push_back('{1'b1, 4'b1011, 1'b0, 4'b0001, 1'b1, 1'b0, 1'b0, 2'd0, 8'h10});
    vt.push_back('{1'b1, 4'b1011, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 8'h10});
    vt.push_back('{1'b1, 4'b1011, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 2'd0, 8'h10});
    vt.push_back('{1'b1, 4'b1011, 1'b0, 4'b0010, 1'b1, 1'b0, 1'b0, 2'd1, 8'h11});
    vt.push_back('{1'b0, 4'b1011, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00});
    vt.push_back('{1'b1, 4'b0011, 1'b0, 4'b0001, 1'b1, 1'b0, 1'b0, 2'd0, 8'h10});
    vt.push_back('{1'b1, 4'b0011, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 8'h10});
    vt.push_back('{1'b0, 4'b0011, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00});
    vt.push_back('{1'b1, 4'b1000, 1'b0, 4'b1000, 1'b1, 1'b0, 1'b0, 2'd3, 8'h13});
    vt.push_back('{1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd3, 8'h13});
    vt.push_back('{1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 2'd3, 8'h13});
    vt.push_back('{1'b1, 4'b1000, 1'b0, 4'b1000, 1'b1, 1'b0, 1'b0, 2'd3, 8'h13});

    foreach (vt[i]) begin
      reset_n = vt[i].rst_n; req = vt[i].req; busy_force = vt[i].busy;
      @(posedge clk); #1;
      chk($sformatf("vec%0d{grant,tx,done,err,id,data}", i),
          {grant, tx_transmit, done, err, active_id, tx_data},
          {vt[i].grant, vt[i].tx, vt[i].done, vt[i].err, vt[i].id, vt[i].txd});
    end

    // Timeout: transmitter never goes busy.
    busy_force = 1'b0;
    do_reset();
    req = 4'b0001;
    @(posedge clk); #1;
    chk("to_grant", grant, 4'b0001);
    tx_cnt = int'(tx_transmit); err_cnt = 0;
    req = '0;
    for (int c = 0; c < 24; c++) begin
      @(posedge clk); #1;
      tx_cnt += int'(tx_transmit);
      err_cnt += int'(err);
    end
    chk("to_tx_cycles", tx_cnt, 16);
    chk("to_err_pulses", err_cnt, 1);
    req = 4'b0011;
    @(posedge clk); #1;
    chk("to_regrant", grant, 4'b0001);
    req = '0;

    // Busy while idle holds off issue.
    do_reset();
    busy_force = 1'b1; req = 4'b1000; gseen = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (grant != 0) gseen++;
    end
    chk("busy_idle_nogrant", gseen, 0);
    busy_force = 1'b0;
    @(posedge clk); #1;
    chk("busy_idle_grant", grant, 4'b1000);
    req = '0;

    // All requesting with the transmitter model.
    use_model = 1'b1;
    do_reset();
    rx_q.delete();
    req_data = 32'h1312_1110; req = 4'b1111;
    ng = 0; nd = 0; done_seen = 1'b0;
    for (int c = 0; c < 400 && nd < 5; c++) begin
      @(posedge clk); #1;
      if (grant != 0) begin
        if (ng < 5) begin
          chk("rr_grant", grant, 4'b0001 << exp_order[ng]);
          chk("rr_data", tx_data, 8'h10 + 8'(exp_order[ng]));
          if (ng > 0) chk("rr_done_before_grant", done_seen, 1);
        end
        ng++;
        done_seen = 1'b0;
      end
      if (done) begin
        chk("rr_spacing_tx", tx_transmit, 0);
        done_seen = 1'b1;
        nd++;
      end
    end
    req = '0;
    chk("rr_ndone", nd, 5);
    chk("rr_ngrant", ng, 5);
    chk("rr_nframes", rx_q.size(), 5);
    for (int k = 0; k < 5 && k < rx_q.size(); k++) begin
      b = 8'h10 + 8'(exp_order[k]);
      chk($sformatf("rr_frame%0d", k), rx_q[k], {1'b1, ^b, b, 1'b0});
    end

    // Data hold: requester changes its data right after grant.
    do_reset();
    rx_q.delete();
    req_data = 32'h13A5_1110; req = 4'b0100;
    @(posedge clk); #1;
    chk("hold_grant", {grant, tx_data}, {4'b0100, 8'hA5});
    req_data = 32'h135A_1110; req = '0;
    hold_bad = 0; got_done = 1'b0;
    for (int c = 0; c < 100 && !got_done; c++) begin
      @(posedge clk); #1;
      if (tx_data !== 8'hA5) hold_bad++;
      if (done) got_done = 1'b1;
    end
    chk("hold_done", got_done, 1);
    chk("hold_active_id", active_id, 2);
    chk("hold_tx_data_changes", hold_bad, 0);
    chk("hold_nframes", rx_q.size(), 1);
    if (rx_q.size() > 0) chk("hold_frame", rx_q[0], {1'b1, 1'b0, 8'hA5, 1'b0});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
